// File: rtl/eth_mac_stats_counter_if.sv
// eth_mac_stats_counter_if: counter read request/response channel.
interface eth_mac_stats_counter_if #(
   parameter int CHAN_WIDTH  = 2,
   parameter int EVT_WIDTH   = 4,
   parameter int COUNT_WIDTH = 32
);
   logic                   rd_req_valid;
   logic                   rd_req_ready;
   logic [CHAN_WIDTH-1:0]  rd_req_chan;
   logic [EVT_WIDTH-1:0]   rd_req_evt;
   logic                   rd_req_clear;
   logic                   rd_resp_valid;
   logic                   rd_resp_ready;
   logic [COUNT_WIDTH-1:0] rd_resp_data;
   logic                   rd_resp_ovf;
   logic                   rd_resp_err;
   modport master (
      output rd_req_valid, rd_req_chan, rd_req_evt, rd_req_clear, rd_resp_ready,
      input  rd_req_ready, rd_resp_valid, rd_resp_data, rd_resp_ovf, rd_resp_err
   );
   modport slave (
      input  rd_req_valid, rd_req_chan, rd_req_evt, rd_req_clear, rd_resp_ready,
      output rd_req_ready, rd_resp_valid, rd_resp_data, rd_resp_ovf, rd_resp_err
   );
endinterface

// File: rtl/eth_mac_stats_counter.sv
// eth_mac_stats_counter: per-channel, per-event pulse counters with a one-deep read port.
module eth_mac_stats_counter #(
   parameter int CHANNELS    = 4,
   parameter int EVENTS      = 9,
   parameter int COUNT_WIDTH = 32,
   parameter int SATURATE    = 1,
   parameter int CHAN_WIDTH  = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
   parameter int EVT_WIDTH   = EVENTS > 1 ? $clog2(EVENTS) : 1
) (
   input logic                         clk,
   input logic                         rst,
   input logic [CHANNELS*EVENTS-1:0]   stat_event,
   input logic                         clear_all,
   eth_mac_stats_counter_if.slave      rd
);
   localparam int N  = CHANNELS * EVENTS;
   localparam int IW = N > 1 ? $clog2(N) : 1;
   logic [COUNT_WIDTH-1:0] cnt [N];
   logic [N-1:0]           ovf;
   logic                   in_range;
   logic                   acc;
   logic [IW-1:0]          sel;
   assign in_range = 32'(rd.rd_req_chan) < CHANNELS && 32'(rd.rd_req_evt) < EVENTS;
   assign sel = IW'(32'(rd.rd_req_chan) * EVENTS + 32'(rd.rd_req_evt));
   assign rd.rd_req_ready = !rd.rd_resp_valid || rd.rd_resp_ready;
   assign acc = rd.rd_req_valid && rd.rd_req_ready;
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) cnt[i] <= '0;
         ovf              <= '0;
         rd.rd_resp_valid <= 1'b0;
         rd.rd_resp_data  <= '0;
         rd.rd_resp_ovf   <= 1'b0;
         rd.rd_resp_err   <= 1'b0;
      end else begin
         // a read-and-clear restarts at the current cycle's event so nothing is lost
         for (int i = 0; i < N; i++)
            if (clear_all) begin
               cnt[i] <= '0;
               ovf[i] <= 1'b0;
            end else if (acc && in_range && rd.rd_req_clear && sel == IW'(i)) begin
               cnt[i] <= COUNT_WIDTH'(stat_event[i]);
               ovf[i] <= 1'b0;
            end else if (stat_event[i]) begin
               cnt[i] <= (&cnt[i] && SATURATE != 0) ? cnt[i] : cnt[i] + 1'b1;
               if (&cnt[i]) ovf[i] <= 1'b1;
            end
         if (acc) begin
            rd.rd_resp_valid <= 1'b1;
            rd.rd_resp_data  <= in_range ? cnt[sel] : '0;
            rd.rd_resp_ovf   <= in_range && ovf[sel];
            rd.rd_resp_err   <= !in_range;
         end else if (rd.rd_resp_ready) begin
            rd.rd_resp_valid <= 1'b0;
         end
      end
   end
endmodule
